// File: rtl/irq_pkg.sv
// Shared types and constants for the irq_ctrl priority interrupt controller.
package irq_pkg;

  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    PEND,
    ACK1,
    GAP,
    ACK2
  } state_e;

  localparam int EOI_NS = 5;
  localparam int EOI_SP = 6;

  localparam logic ADDR_CMD = 1'b0;
  localparam logic ADDR_IMR = 1'b1;

  function automatic logic [7:0] vector_of(input logic [7:0] base, input logic [IDX_W-1:0] idx);
    return base + 8'(idx);
  endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// CPU-side bus and request lines of the interrupt controller.
interface irq_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  logic [NUM_IRQ-1:0] irq;
  logic               intr;
  logic               intaN;
  logic               csN;
  logic               wrN;
  logic               rdN;
  logic               a0;
  logic [7:0]         din;
  logic [7:0]         dout;
  logic               dout_en;

  modport master (
    output irq, intaN, csN, wrN, rdN, a0, din,
    input  intr, dout, dout_en
  );

  modport slave (
    input  irq, intaN, csN, wrN, rdN, a0, din,
    output intr, dout, dout_en
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder: index 0 has the highest priority.
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]     vec_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Priority interrupt controller: edge-captured requests, fully nested priority,
// two-pulse INTA vector delivery and EOI-cleared in-service tracking.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int         NUM_IRQ     = 8,
  parameter logic [7:0] VECTOR_BASE = 8'h10
) (
  input logic       clk,
  input logic       reset,
  irq_ctrl_if.slave bus
);

  localparam logic [NUM_IRQ-1:0] ONE      = NUM_IRQ'(1);
  localparam logic [IDX_W-1:0]   SPUR_IDX = IDX_W'(NUM_IRQ - 1);

  logic [NUM_IRQ-1:0] sync1_q, sync2_q, edge_prev_q;
  logic [NUM_IRQ-1:0] irr_q, isr_q, imr_q;
  logic [NUM_IRQ-1:0] irr_d, isr_d, imr_d;
  logic               wr_prev_q, inta_prev_q;
  state_e             state_q;
  logic               intr_q;
  logic [IDX_W-1:0]   ack_idx_q;
  logic               spur_q;

  logic               req_valid, isr_valid, req_go;
  logic [IDX_W-1:0]   req_idx, isr_idx;
  logic [NUM_IRQ-1:0] rise_det, eoi_mask, ack_mask;
  logic               wr_commit, cmd_wr, imr_wr, ns_eoi, sp_eoi;
  logic               inta_fall, inta_rise, ack_done;
  logic               vec_drive, rd_drive;
  logic               unused_din;

  irq_prio_enc #(.N(NUM_IRQ)) u_req_enc (
    .vec_i   (irr_q & ~imr_q),
    .valid_o (req_valid),
    .idx_o   (req_idx)
  );

  irq_prio_enc #(.N(NUM_IRQ)) u_isr_enc (
    .vec_i   (isr_q),
    .valid_o (isr_valid),
    .idx_o   (isr_idx)
  );

  // Fully nested: a request is only raised if it outranks everything in service.
  assign req_go = req_valid && (!isr_valid || (req_idx < isr_idx));

  assign rise_det  = sync2_q & ~edge_prev_q;
  assign wr_commit = !bus.csN && !bus.wrN && wr_prev_q;
  assign inta_fall = !bus.intaN && inta_prev_q;
  assign inta_rise = bus.intaN && !inta_prev_q;

  assign cmd_wr = wr_commit && (bus.a0 == ADDR_CMD);
  assign imr_wr = wr_commit && (bus.a0 == ADDR_IMR);
  assign ns_eoi = cmd_wr && bus.din[EOI_NS];
  assign sp_eoi = cmd_wr && !bus.din[EOI_NS] && bus.din[EOI_SP] && (int'(bus.din[2:0]) < NUM_IRQ);
  assign unused_din = ^{bus.din[7], bus.din[4:3]};

  assign ack_done = (state_q == ACK2) && inta_rise && !spur_q;

  always_comb begin
    eoi_mask = '0;
    if (ns_eoi && isr_valid) eoi_mask = ONE << isr_idx;
    else if (sp_eoi)         eoi_mask = ONE << bus.din[2:0];
    ack_mask = ack_done ? (ONE << ack_idx_q) : '0;
    // A fresh edge outranks the acknowledge clear; EOI clears before the ack sets.
    irr_d = (irr_q & ~ack_mask) | rise_det;
    isr_d = (isr_q & ~eoi_mask) | ack_mask;
    imr_d = imr_wr ? bus.din[NUM_IRQ-1:0] : imr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      edge_prev_q <= '0;
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= '1;
      wr_prev_q   <= 1'b1;
      inta_prev_q <= 1'b1;
    end else begin
      sync1_q     <= bus.irq;
      sync2_q     <= sync1_q;
      edge_prev_q <= sync2_q;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      wr_prev_q   <= bus.wrN;
      inta_prev_q <= bus.intaN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      intr_q    <= 1'b0;
      ack_idx_q <= '0;
      spur_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inta_fall) begin
            state_q   <= ACK1;
            ack_idx_q <= SPUR_IDX;
            spur_q    <= 1'b1;
          end else if (req_go) begin
            state_q <= PEND;
            intr_q  <= 1'b1;
          end
        end
        PEND: begin
          if (inta_fall) begin
            state_q   <= ACK1;
            intr_q    <= 1'b0;
            ack_idx_q <= req_go ? req_idx : SPUR_IDX;
            spur_q    <= !req_go;
          end else if (!req_go) begin
            state_q <= IDLE;
            intr_q  <= 1'b0;
          end
        end
        ACK1:    if (inta_rise) state_q <= GAP;
        GAP:     if (inta_fall) state_q <= ACK2;
        ACK2:    if (inta_rise) state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          intr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_drive = (state_q == ACK2) && !bus.intaN;
  assign rd_drive  = !bus.csN && !bus.rdN;

  always_comb begin
    bus.dout = 8'h00;
    if (vec_drive)     bus.dout = vector_of(VECTOR_BASE, ack_idx_q);
    else if (rd_drive) bus.dout = bus.a0 ? 8'(imr_q) : 8'(irr_q);
  end

  assign bus.dout_en = vec_drive || rd_drive;
  assign bus.intr    = intr_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed plus randomized bench for irq_ctrl against a level-set reference model.
module tb_irq_ctrl;
  localparam int         N    = 8;
  localparam logic [7:0] BASE = 8'h10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  irq_ctrl_if #(.NUM_IRQ(N)) bus ();

  irq_ctrl #(.NUM_IRQ(N), .VECTOR_BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: one flag per level for pending, in-service and masked.
  bit pend_m[N];
  bit insv_m[N];
  bit mask_m[N];

  function automatic logic [7:0] pack(input bit a[N]);
    logic [7:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  function automatic int m_winner();
    for (int i = 0; i < N; i++) if (pend_m[i] && !mask_m[i]) return i;
    return -1;
  endfunction

  function automatic int m_top_isr();
    for (int i = 0; i < N; i++) if (insv_m[i]) return i;
    return N;
  endfunction

  function automatic bit m_req();
    int w = m_winner();
    return (w >= 0) && (w < m_top_isr());
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin
      pend_m[i] = 1'b0;
      insv_m[i] = 1'b0;
      mask_m[i] = 1'b1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic a, input logic [7:0] d);
    int t;
    bus.a0 = a; bus.din = d; bus.csN = 1'b0; bus.wrN = 1'b0;
    tick();
    bus.wrN = 1'b1; bus.csN = 1'b1;
    tick();
    if (a) begin
      for (int i = 0; i < N; i++) mask_m[i] = d[i];
    end else if (d[5]) begin
      t = m_top_isr();
      if (t < N) insv_m[t] = 1'b0;
    end else if (d[6]) begin
      if (int'(d[2:0]) < N) insv_m[d[2:0]] = 1'b0;
    end
    $display("write a0=%0d din=%h", a, d);
  endtask

  task automatic bus_read(input logic a, output logic [7:0] v, output logic en);
    bus.a0 = a; bus.csN = 1'b0; bus.rdN = 1'b0;
    #1;
    v  = bus.dout;
    en = bus.dout_en;
    bus.csN = 1'b1; bus.rdN = 1'b1;
    #1;
  endtask

  task automatic check_regs(input string tag);
    logic [7:0] v;
    logic       en;
    bus_read(1'b0, v, en);
    chk({tag, "_irr"}, v, pack(pend_m));
    chk({tag, "_rd_en"}, 8'(en), 8'h01);
    bus_read(1'b1, v, en);
    chk({tag, "_imr"}, v, pack(mask_m));
    chk({tag, "_isr"}, 8'(dut.isr_q), pack(insv_m));
    chk({tag, "_intr"}, 8'(bus.intr), 8'(m_req()));
    chk({tag, "_idle_en"}, 8'(bus.dout_en), 8'h00);
  endtask

  task automatic pulse(input logic [7:0] m);
    bus.irq = m[N-1:0];
    tick(); tick();
    bus.irq = '0;
    tick(); tick();
    for (int i = 0; i < N; i++) if (m[i]) pend_m[i] = 1'b1;
  endtask

  task automatic wait_intr(input string tag);
    int n = 0;
    while (bus.intr !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_intr_wait"}, 8'(bus.intr), 8'h01);
  endtask

  task automatic do_ack(input string tag);
    bit         req = m_req();
    int         w   = m_winner();
    logic [7:0] exp = req ? BASE + 8'(w) : BASE + 8'(N - 1);
    logic [7:0] v;
    bus.intaN = 1'b0; tick();
    bus.intaN = 1'b1; tick();
    bus.intaN = 1'b0; tick();
    v = bus.dout;
    chk({tag, "_vec"}, v, exp);
    chk({tag, "_vec_en"}, 8'(bus.dout_en), 8'h01);
    bus.intaN = 1'b1; tick();
    tick();
    if (req) begin
      pend_m[w] = 1'b0;
      insv_m[w] = 1'b1;
    end
    $display("ack %s vector=%h", tag, v);
  endtask

  initial begin
    logic [7:0] v;
    logic       en;
    logic [7:0] r;

    reset = 1'b1;
    bus.irq = '0; bus.intaN = 1'b1; bus.csN = 1'b1; bus.wrN = 1'b1;
    bus.rdN = 1'b1; bus.a0 = 1'b0; bus.din = 8'h00;
    m_reset();
    tick(); tick(); tick();
    chk("rst_intr", 8'(bus.intr), 8'h00);
    chk("rst_dout", bus.dout, 8'h00);
    chk("rst_dout_en", 8'(bus.dout_en), 8'h00);
    reset = 1'b0;
    tick();
    check_regs("reset");

    // Basic capture latency and acknowledge of irq[3].
    bus_write(1'b1, 8'h00);
    bus.irq[3] = 1'b1;
    bus.a0 = 1'b0; bus.csN = 1'b0; bus.rdN = 1'b0;
    tick(); chk("lat_e1_irr", bus.dout, 8'h00);
    tick(); chk("lat_e2_irr", bus.dout, 8'h00);
    tick(); chk("lat_e3_irr", bus.dout, 8'h08);
    chk("lat_e3_intr", 8'(bus.intr), 8'h00);
    tick(); chk("lat_e4_intr", 8'(bus.intr), 8'h01);
    bus.csN = 1'b1; bus.rdN = 1'b1; bus.irq = '0;
    pend_m[3] = 1'b1;
    do_ack("irq3");
    check_regs("after_irq3");
    bus_write(1'b0, 8'h20);

    // Simultaneous edges, nesting hold-off, non-specific EOI.
    pulse(8'h24);
    check_regs("two_req");
    do_ack("irq2");
    check_regs("irq5_held");
    bus_write(1'b0, 8'h20);
    check_regs("after_ns_eoi");
    do_ack("irq5");
    bus_write(1'b0, 8'h20);

    // Nested interrupt over irq[4], then specific EOI of level 4.
    pulse(8'h10);
    wait_intr("irq4");
    do_ack("irq4");
    pulse(8'h02);
    wait_intr("irq1");
    do_ack("irq1_nested");
    check_regs("nested");
    bus_write(1'b0, 8'h44);
    check_regs("sp_eoi");
    bus_write(1'b0, 8'h20);

    // Masked request, released by IMR write.
    bus_write(1'b1, 8'hFF);
    pulse(8'h01);
    check_regs("masked");
    bus_write(1'b1, 8'hFE);
    chk("unmask_intr", 8'(bus.intr), 8'h01);
    do_ack("irq0");
    bus_write(1'b0, 8'h20);
    bus_write(1'b1, 8'h00);
    check_regs("clean");

    // Spurious acknowledge.
    do_ack("spurious");
    check_regs("spurious");

    // Reset during GAP, with intaN falling on the reset clock.
    pulse(8'h04);
    wait_intr("pre_rst");
    bus.intaN = 1'b0; tick();
    bus.intaN = 1'b1; tick();
    reset = 1'b1;
    bus.intaN = 1'b0; tick();
    chk("midrst_intr", 8'(bus.intr), 8'h00);
    chk("midrst_dout_en", 8'(bus.dout_en), 8'h00);
    bus.intaN = 1'b1; tick();
    reset = 1'b0;
    tick();
    m_reset();
    check_regs("midrst");

    // IMR readback and re-trigger coinciding with the acknowledge clear.
    r = 8'($urandom);
    bus_write(1'b1, r);
    bus_read(1'b1, v, en);
    chk("imr_read", v, r);
    chk("imr_read_en", 8'(en), 8'h01);
    bus_write(1'b1, 8'h00);
    pulse(8'h40);
    check_regs("pre_retrig");
    bus.intaN = 1'b0; tick();
    bus.intaN = 1'b1; bus.irq[6] = 1'b1; tick();
    bus.intaN = 1'b0; tick();
    chk("retrig_vec", bus.dout, 8'h16);
    bus.intaN = 1'b1; tick();
    bus.irq = '0; tick();
    insv_m[6] = 1'b1;
    check_regs("retrig");
    bus_write(1'b0, 8'h20);
    check_regs("retrig_eoi");
    do_ack("irq6_again");
    bus_write(1'b0, 8'h20);

    // Randomized traffic against the model.
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(0, 3) == 0) bus_write(1'b1, 8'($urandom & $urandom & $urandom));
      pulse(8'($urandom));
      check_regs("rnd_pulse");
      for (int k = 0; k < 10 && m_req(); k++) begin
        do_ack("rnd");
        case ($urandom_range(0, 2))
          0:       bus_write(1'b0, 8'h20);
          1:       bus_write(1'b0, 8'h40 | 8'($urandom_range(0, 7)));
          default: tick();
        endcase
        check_regs("rnd_ack");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Priority interrupt controller that replaces the single-flip-flop interrupt trigger in the basic 8086 system.
- Accepts up to NUM_IRQ edge-triggered requests and resolves priority, with irq[0] the highest.
- Drives the CPU intr line and sequences the two-pulse INTA handshake.
- Supplies the vector byte on the low data lane and tracks in-service levels, which software clears by an EOI write through the I/O decoder select.

Parameters:
NUM_IRQ, 8, number of request inputs; valid range 2..8
VECTOR_BASE, 8'h10, vector for irq[0]; irq[n] gets VECTOR_BASE+n, with 8-bit wrap

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
irq  input  NUM_IRQ  asynchronous request lines; a rising edge requests service
intr  output  1  interrupt request to CPU
intaN  input  1  CPU interrupt acknowledge, active low, synchronous to clk
csN  input  1  register select from io_dec, active low
wrN  input  1  bus write strobe, active low
rdN  input  1  bus read strobe, active low
a0  input  1  register address: 0 = command/IRR, 1 = IMR
din  input  8  write data from the low data lane
dout  output  8  read data or vector byte
dout_en  output  1  drive enable for the external tri-state buffer on the low data lane

Behaviour:
- Reset: IRR=0, ISR=0, IMR=all ones (all levels masked), intr=0, dout=0, dout_en=0, FSM=IDLE, synchronizers and edge registers cleared.
- Request capture: each irq passes a 2-FF synchronizer, then a rising-edge detector.
  - An edge at the pin sets its IRR bit on the 3rd clk edge.
  - intr is registered and rises on the 4th clk edge.
- Simultaneous set and clear of the same IRR bit: set wins.
- Bus strobes: wrN, rdN and intaN are sampled each clk; edges are detected against the previous sample.
  - A write commits on the clk where wrN is first sampled low with csN=0.
- Writes with a0=1: IMR <= din[NUM_IRQ-1:0].
- Writes with a0=0 and din[5]=1: non-specific EOI, clears the highest-priority set ISR bit.
- Writes with a0=0, din[5]=0 and din[6]=1: specific EOI, clears ISR[din[2:0]]; levels >= NUM_IRQ are ignored.
- Writes with a0=0 and other encodings: no effect.
- Reads (csN=0, rdN=0): dout = a0 ? IMR : IRR, with upper bits 0; dout_en=1 combinationally while both are low.
- Eligibility: a level is eligible when IRR & ~IMR.
  - The winner is the lowest eligible index.
  - intr requests only if the winner has higher priority than the highest set ISR bit (fully nested mode).
- FSM:
  - IDLE: intr=0. Go to PEND when a winner exists. If intaN falls in IDLE, go to ACK1 with the spurious flag set.
  - PEND: intr=1. If the winner disappears (masked) before intaN falls, return to IDLE and drop intr.
  - PEND to ACK1 on intaN falling: latch the winner index, drop intr.
  - ACK1 to GAP on intaN rising.
  - GAP to ACK2 on intaN falling.
  - ACK2: dout = VECTOR_BASE+latched index, dout_en=1 while intaN is low.
  - ACK2 to IDLE on intaN rising: clear IRR[latched], set ISR[latched].
  - Spurious cycle: vector = VECTOR_BASE+NUM_IRQ-1, no IRR/ISR change.
- Latched winner is immune to IMR/IRR changes during ACK1..ACK2.
- EOI and acknowledge completing on the same clk: the EOI clear is applied first, then the ISR set.
- Reset mid-handshake: FSM returns to IDLE and dout_en drops on the next clk edge.
- During ACK1/GAP/ACK2, register reads are still honoured, but the vector takes priority on dout whenever intaN is low.

Decomposition:
- Package irq_pkg:
  - FSM state enum: IDLE, PEND, ACK1, GAP, ACK2.
  - EOI command bit positions: EOI_NS=5, EOI_SP=6.
  - Register address constants: ADDR_CMD=0, ADDR_IMR=1.
- Sub-module irq_prio_enc: combinational lowest-index-first encoder returning valid and index.
  - Instantiated twice: once on IRR&~IMR, once on ISR.

Test Plan:
- Reset, write IMR=8'h00, pulse irq[3] -> IRR=8'h08 on the 3rd clk, intr=1 on the 4th; two INTA pulses -> vector 8'h13 on the 2nd pulse; afterwards IRR=0, ISR=8'h08, intr=0.
- irq[5] and irq[2] edges in the same cycle -> first acknowledge returns 8'h12. irq[5] stays pending with intr=0 until a non-specific EOI (din=8'h20) -> intr rises, second acknowledge returns 8'h15.
- ISR=8'h10 (irq[4] in service), then irq[1] edge -> nested intr, vector 8'h11, ISR=8'h12. Specific EOI din=8'h44 -> ISR=8'h02.
- IMR=8'hFF, pulse irq[0] -> IRR bit 0 set, intr stays 0. Write IMR=8'hFE -> intr=1 within 2 clks.
- INTA pulses with no request pending -> vector 8'h17, ISR unchanged. Separately, assert reset during GAP -> IDLE, intr=0, dout_en=0, IRR=ISR=0, IMR=8'hFF.
- Register reads: a0=1 returns IMR. Also, an irq[6] edge coinciding with the ACK2-end clear of IRR bit 6 leaves IRR bit 6 set.
